// File: rtl/arith_exec_unit_pkg.sv
// ============================================================================
// Module : exec_unit_pkg
// Brief  : Shared types and default widths for the arithmetic execution unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_unit_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    WB   = 3'd2,
    DONE = 3'd3,
    ACK  = 3'd4
  } fu_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } fu_op_t;

endpackage

`default_nettype wire

// File: rtl/arith_exec_unit_if.sv
// ============================================================================
// Module : arith_exec_unit_if
// Brief  : Dispatch <-> execution-unit handshake bundle for one issue lane.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arith_exec_unit_if
  import exec_unit_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W
);

  logic              start_adder;
  logic              start_multiplier;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [REG_W-1:0]  dest_rd;
  logic              reset_adder_complete;
  logic              reset_multiplier_complete;

  logic              adder_busy;
  logic              multiplier_busy;
  logic              reset_instruction_in_progress_adder;
  logic              reset_instruction_in_progress_multiplier;
  logic              adder_write_enable;
  logic              multiplier_write_enable;
  logic [DATA_W-1:0] adder_result;
  logic [DATA_W-1:0] multiplier_result;
  logic [REG_W-1:0]  adder_rd;
  logic [REG_W-1:0]  multiplier_rd;
  logic              adder_complete;
  logic              multiplier_complete;
  logic              adder_reset_operation_complete;
  logic              multiplier_reset_operation_complete;

  modport master (
    output start_adder, start_multiplier, operand_a, operand_b, dest_rd,
           reset_adder_complete, reset_multiplier_complete,
    input  adder_busy, multiplier_busy,
           reset_instruction_in_progress_adder, reset_instruction_in_progress_multiplier,
           adder_write_enable, multiplier_write_enable,
           adder_result, multiplier_result, adder_rd, multiplier_rd,
           adder_complete, multiplier_complete,
           adder_reset_operation_complete, multiplier_reset_operation_complete
  );

  modport slave (
    input  start_adder, start_multiplier, operand_a, operand_b, dest_rd,
           reset_adder_complete, reset_multiplier_complete,
    output adder_busy, multiplier_busy,
           reset_instruction_in_progress_adder, reset_instruction_in_progress_multiplier,
           adder_write_enable, multiplier_write_enable,
           adder_result, multiplier_result, adder_rd, multiplier_rd,
           adder_complete, multiplier_complete,
           adder_reset_operation_complete, multiplier_reset_operation_complete
  );

endinterface

`default_nettype wire

// File: rtl/arith_exec_unit_engine.sv
// ============================================================================
// Module : fu_engine
// Brief  : One execution engine: start/armed handshake, latency counter, WB strobe, complete/ack.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_engine
  import exec_unit_pkg::*;
#(
  parameter int     DATA_W  = DEFAULT_DATA_W,
  parameter int     REG_W   = DEFAULT_REG_W,
  parameter int     LATENCY = 1,
  parameter fu_op_t OP      = OP_ADD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              rip_o,
  output logic              we_o,
  output logic [DATA_W-1:0] result_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              complete_o,
  output logic              ack_o
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  fu_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic [DATA_W-1:0] a_q, b_q, result_q, result_d;
  logic [REG_W-1:0]  rd_q;
  logic              busy_q, rip_q, we_q, complete_q, ack_q;
  logic              accept_d;

  if (OP == OP_ADD) begin : g_add
    assign result_d = a_q + b_q;
  end else begin : g_mul
    assign result_d = a_q * b_q;
  end

  assign accept_d = (state_q == IDLE) && start_i && armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      rip_q      <= 1'b0;
      we_q       <= 1'b0;
      complete_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      ack_q <= 1'b0;
      // A start level held through an op must drop before it can launch again
      if (!start_i) armed_q <= 1'b1;
      if (accept_d) rip_q <= 1'b1;
      else if (!start_i) rip_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            a_q     <= a_i;
            b_q     <= b_i;
            rd_q    <= rd_i;
            cnt_q   <= CNT_W'(LATENCY);
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= result_d;
            we_q     <= 1'b1;
            state_q  <= WB;
          end
        end
        WB: begin
          complete_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (clear_i) begin
            complete_q <= 1'b0;
            ack_q      <= 1'b1;
            state_q    <= ACK;
          end
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign rip_o      = rip_q;
  assign we_o       = we_q;
  assign result_o   = result_q;
  assign rd_o       = rd_q;
  assign complete_o = complete_q;
  assign ack_o      = ack_q;

endmodule

`default_nettype wire

// File: rtl/arith_exec_unit.sv
// ============================================================================
// Module : arith_exec_unit
// Brief  : Issue-lane execution unit with independent adder and multiplier engines.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_exec_unit
  import exec_unit_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int REG_W       = DEFAULT_REG_W,
  parameter int ADD_LATENCY = 1,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  arith_exec_unit_if.slave   bus
);

  fu_engine #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .LATENCY(ADD_LATENCY),
    .OP     (OP_ADD)
  ) u_adder (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.start_adder),
    .a_i       (bus.operand_a),
    .b_i       (bus.operand_b),
    .rd_i      (bus.dest_rd),
    .clear_i   (bus.reset_adder_complete),
    .busy_o    (bus.adder_busy),
    .rip_o     (bus.reset_instruction_in_progress_adder),
    .we_o      (bus.adder_write_enable),
    .result_o  (bus.adder_result),
    .rd_o      (bus.adder_rd),
    .complete_o(bus.adder_complete),
    .ack_o     (bus.adder_reset_operation_complete)
  );

  fu_engine #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .LATENCY(MUL_LATENCY),
    .OP     (OP_MUL)
  ) u_multiplier (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.start_multiplier),
    .a_i       (bus.operand_a),
    .b_i       (bus.operand_b),
    .rd_i      (bus.dest_rd),
    .clear_i   (bus.reset_multiplier_complete),
    .busy_o    (bus.multiplier_busy),
    .rip_o     (bus.reset_instruction_in_progress_multiplier),
    .we_o      (bus.multiplier_write_enable),
    .result_o  (bus.multiplier_result),
    .rd_o      (bus.multiplier_rd),
    .complete_o(bus.multiplier_complete),
    .ack_o     (bus.multiplier_reset_operation_complete)
  );

endmodule

`default_nettype wire

// File: tb/tb_arith_exec_unit.sv
// ============================================================================
// Module : tb_arith_exec_unit
// Brief  : Scoreboard bench for arith_exec_unit with directed add/mul vectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_exec_unit;
  import exec_unit_pkg::*;

  localparam int ADD_L = 1;
  localparam int MUL_L = 3;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_add[$];
  exp_t q_mul[$];

  arith_exec_unit_if #(.DATA_W(32), .REG_W(5)) bus ();

  arith_exec_unit #(
    .DATA_W(32), .REG_W(5), .ADD_LATENCY(ADD_L), .MUL_LATENCY(MUL_L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Cycle index in which outputs are currently observed (after edge cyc)
  function automatic int now_cycle();
    return cyc + 1;
  endfunction

  function automatic logic [83:0] all_outs();
    return {bus.adder_busy, bus.multiplier_busy,
            bus.reset_instruction_in_progress_adder, bus.reset_instruction_in_progress_multiplier,
            bus.adder_write_enable, bus.multiplier_write_enable,
            bus.adder_result, bus.multiplier_result, bus.adder_rd, bus.multiplier_rd,
            bus.adder_complete, bus.multiplier_complete,
            bus.adder_reset_operation_complete, bus.multiplier_reset_operation_complete};
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? bus.multiplier_busy : bus.adder_busy;
  endfunction
  function automatic logic get_rip(input int sel);
    return (sel != 0) ? bus.reset_instruction_in_progress_multiplier
                      : bus.reset_instruction_in_progress_adder;
  endfunction
  function automatic logic get_cpl(input int sel);
    return (sel != 0) ? bus.multiplier_complete : bus.adder_complete;
  endfunction
  function automatic logic get_ack(input int sel);
    return (sel != 0) ? bus.multiplier_reset_operation_complete
                      : bus.adder_reset_operation_complete;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) bus.start_multiplier = v;
    else bus.start_adder = v;
  endtask

  task automatic set_clr(input int sel, input logic v);
    if (sel != 0) bus.reset_multiplier_complete = v;
    else bus.reset_adder_complete = v;
  endtask

  // hold = number of cycles start stays high; 0 keeps it high on return
  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res,
                       input int hold, output int t);
    exp_t e;
    int lat;
    lat = (sel != 0) ? MUL_L : ADD_L;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_rd   = rd;
    set_start(sel, 1'b1);
    t     = cyc + 1;
    e.res = exp_res;
    e.rd  = rd;
    e.cyc = t + lat + 1;
    if (sel != 0) q_mul.push_back(e);
    else q_add.push_back(e);
    step();
    check((sel != 0) ? "mul_busy_after_accept" : "add_busy_after_accept", get_busy(sel), 1'b1);
    check((sel != 0) ? "mul_rip_after_accept" : "add_rip_after_accept", get_rip(sel), 1'b1);
    for (int i = 1; i < hold; i++) step();
    if (hold > 0) set_start(sel, 1'b0);
  endtask

  task automatic wait_done(input int sel, input int exp_cyc);
    for (int i = 0; i < 40; i++) begin
      if (get_cpl(sel)) break;
      step();
    end
    check((sel != 0) ? "mul_complete_cycle" : "add_complete_cycle",
          get_cpl(sel) ? now_cycle() : -1, exp_cyc);
  endtask

  task automatic clear(input int sel);
    set_clr(sel, 1'b1);
    step();
    set_clr(sel, 1'b0);
    check((sel != 0) ? "mul_ack_pulse" : "add_ack_pulse", {get_ack(sel), get_cpl(sel)}, 2'b10);
    step();
    check((sel != 0) ? "mul_idle_after_ack" : "add_idle_after_ack",
          {get_ack(sel), get_busy(sel)}, 2'b00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.adder_write_enable === 1'b1) begin
      if (q_add.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL add_unexpected_write: got write in cycle %0d, required none", now_cycle());
      end else begin
        e = q_add.pop_front();
        check("add_result", bus.adder_result, e.res);
        check("add_rd", bus.adder_rd, e.rd);
        check("add_wb_cycle", now_cycle(), e.cyc);
      end
    end
    if (bus.multiplier_write_enable === 1'b1) begin
      if (q_mul.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mul_unexpected_write: got write in cycle %0d, required none", now_cycle());
      end else begin
        e = q_mul.pop_front();
        check("mul_result", bus.multiplier_result, e.res);
        check("mul_rd", bus.multiplier_rd, e.rd);
        check("mul_wb_cycle", now_cycle(), e.cyc);
      end
    end
  end

  initial begin
    int t, ta, tm;
    bus.start_adder = 1'b0;
    bus.start_multiplier = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_rd = '0;
    bus.reset_adder_complete = 1'b0;
    bus.reset_multiplier_complete = 1'b0;
    step();
    step();
    check("reset_outputs", all_outs(), 84'd0);
    reset = 1'b0;
    step();

    // Add 5+7 rd=3, start held two cycles
    issue(0, 32'd5, 32'd7, 5'd3, 32'd12, 2, t);
    wait_done(0, t + ADD_L + 2);
    clear(0);

    // Wrap-around cases
    issue(1, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFE, 1, t);
    wait_done(1, t + MUL_L + 2);
    clear(1);
    issue(0, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0, 1, t);
    wait_done(0, t + ADD_L + 2);
    clear(0);

    // Start held through the whole op launches exactly one
    issue(0, 32'd10, 32'd20, 5'd4, 32'd30, 0, t);
    wait_done(0, t + ADD_L + 2);
    clear(0);
    step();
    step();
    step();
    check("add_no_relaunch_while_held", bus.adder_busy, 1'b0);
    set_start(0, 1'b0);
    step();
    issue(0, 32'd1, 32'd2, 5'd5, 32'd3, 1, t);
    wait_done(0, t + ADD_L + 2);
    clear(0);

    // Reset sampled at edge T+2 of a multiply aborts it
    issue(1, 32'd6, 32'd7, 5'd7, 32'd42, 1, t);
    step();
    reset = 1'b1;
    step();
    void'(q_mul.pop_back());
    check("reset_mid_mul_outputs", all_outs(), 84'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    issue(1, 32'd3, 32'd4, 5'd9, 32'd12, 1, t);
    wait_done(1, t + MUL_L + 2);
    clear(1);

    // Back-to-back add then mul, cleared independently
    issue(0, 32'd11, 32'd22, 5'd2, 32'd33, 1, ta);
    issue(1, 32'd5, 32'd9, 5'd6, 32'd45, 1, tm);
    check("overlap_mul_accept_edge", tm, ta + 1);
    wait_done(0, ta + ADD_L + 2);
    clear(0);
    check("mul_unaffected_by_add_clear", bus.multiplier_busy, 1'b1);
    wait_done(1, tm + MUL_L + 2);
    clear(1);

    // Clear during EXEC is ignored
    issue(0, 32'd40, 32'd2, 5'd11, 32'd42, 1, t);
    set_clr(0, 1'b1);
    step();
    set_clr(0, 1'b0);
    wait_done(0, t + ADD_L + 2);
    step();
    step();
    check("add_complete_holds", {bus.adder_complete, bus.adder_busy}, 2'b11);
    clear(0);

    // Start and clear together in DONE: clear wins, no relaunch
    issue(0, 32'd100, 32'd200, 5'd1, 32'd300, 1, t);
    wait_done(0, t + ADD_L + 2);
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd9;
    set_start(0, 1'b1);
    set_clr(0, 1'b1);
    step();
    set_start(0, 1'b0);
    set_clr(0, 1'b0);
    check("start_clear_in_done_ack", bus.adder_reset_operation_complete, 1'b1);
    step();
    step();
    check("start_clear_in_done_idle", bus.adder_busy, 1'b0);

    for (int i = 0; i < 6; i++) step();
    check("add_queue_drained", q_add.size(), 0);
    check("mul_queue_drained", q_mul.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
